// File: rtl/fir_serial_seq.sv
`default_nettype none
// ============================================================================
// Module   : fir_serial_seq
// Brief    : Time-multiplexed FIR sequencer; one shared signed MAC walks all
//            NUM_TAPS taps per accepted sample. Optional macro
//            FIR_SEQ_MUL_PIPE_EN registers the product and adds a DRAIN state.
// Revision : 1.0 - initial release
// ============================================================================
module fir_serial_seq #(
   parameter int INPUT_WIDTH  = 16,
   parameter int COEFF_WIDTH  = 8,
   parameter int OUTPUT_WIDTH = 26,
   parameter int NUM_TAPS     = 37,
   parameter int ACC_WIDTH    = 32,
   parameter int OUT_SHIFT    = 0
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          valid_in,
   output logic                          ready_in,
   input  logic [INPUT_WIDTH-1:0]        din,
   output logic                          valid_out,
   output logic [OUTPUT_WIDTH-1:0]       dout,
   input  logic                          coef_we,
   input  logic [$clog2(NUM_TAPS)-1:0]   coef_addr,
   input  logic [COEFF_WIDTH-1:0]        coef_wdata,
   output logic                          busy
);

   localparam int              c_aw   = $clog2(NUM_TAPS);
   localparam int              c_pw   = INPUT_WIDTH + COEFF_WIDTH;
   localparam logic [c_aw-1:0] c_last = c_aw'(NUM_TAPS - 1);

   localparam logic [1:0] c_st_idle  = 2'd0;
   localparam logic [1:0] c_st_mac   = 2'd1;
`ifdef FIR_SEQ_MUL_PIPE_EN
   localparam logic [1:0] c_st_drain = 2'd2;
`endif
   localparam logic [1:0] c_st_done  = 2'd3;

   logic [1:0]                    r_state;
   logic [1:0]                    w_next_state;
   logic [c_aw-1:0]               r_wr_ptr;
   logic [c_aw-1:0]               r_rd_ptr;
   logic [c_aw-1:0]               r_k;
   logic signed [ACC_WIDTH-1:0]   r_acc;
   logic [OUTPUT_WIDTH-1:0]       r_dout;
   logic signed [INPUT_WIDTH-1:0] r_hist [NUM_TAPS];
   logic signed [COEFF_WIDTH-1:0] r_coef [NUM_TAPS];
   logic signed [c_pw-1:0]        w_prod;
   logic signed [ACC_WIDTH-1:0]   w_addend;
   logic signed [ACC_WIDTH-1:0]   w_acc_next;
   logic                          w_coef_wr;

   // Both operands are sign-extended to the full product width before multiplying.
   assign w_prod     = c_pw'(r_hist[r_rd_ptr]) * c_pw'(r_coef[r_k]);
   assign w_acc_next = r_acc + w_addend;
   assign w_coef_wr  = coef_we && (r_state == c_st_idle)
                       && ({1'b0, coef_addr} < (c_aw + 1)'(NUM_TAPS));
   assign dout       = r_dout;

`ifdef FIR_SEQ_MUL_PIPE_EN
   logic signed [c_pw-1:0] r_prod;
   assign w_addend = ACC_WIDTH'(r_prod);

   always_ff @(posedge clk) begin
      if (rst || (r_state == c_st_idle)) begin
         r_prod <= '0;
      end else if (r_state == c_st_mac) begin
         r_prod <= w_prod;
      end
   end
`else
   assign w_addend = ACC_WIDTH'(w_prod);
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= c_st_idle;
      end else begin
         r_state <= w_next_state;
      end
   end

   always_comb begin
      w_next_state = r_state;
      unique case (r_state)
         c_st_idle: begin
            if (valid_in) w_next_state = c_st_mac;
         end
         c_st_mac: begin
            if (r_k == c_last) begin
`ifdef FIR_SEQ_MUL_PIPE_EN
               w_next_state = c_st_drain;
`else
               w_next_state = c_st_done;
`endif
            end
         end
`ifdef FIR_SEQ_MUL_PIPE_EN
         c_st_drain: w_next_state = c_st_done;
`endif
         default: w_next_state = c_st_idle;
      endcase
   end

   always_comb begin
      ready_in  = 1'b0;
      busy      = 1'b1;
      valid_out = 1'b0;
      unique case (r_state)
         c_st_idle: begin
            ready_in = 1'b1;
            busy     = 1'b0;
         end
         c_st_done: valid_out = 1'b1;
         default: ;
      endcase
   end

   // dout is loaded on the final accumulate so it is already valid in DONE.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_k      <= '0;
         r_acc    <= '0;
         r_dout   <= '0;
         for (int i = 0; i < NUM_TAPS; i++) begin
            r_hist[i] <= '0;
            r_coef[i] <= '0;
         end
      end else begin
         if (w_coef_wr) r_coef[coef_addr] <= coef_wdata;
         unique case (r_state)
            c_st_idle: begin
               if (valid_in) begin
                  r_hist[r_wr_ptr] <= din;
                  r_rd_ptr         <= r_wr_ptr;
                  r_k              <= '0;
                  r_acc            <= '0;
               end
            end
            c_st_mac: begin
               r_acc    <= w_acc_next;
               r_rd_ptr <= (r_rd_ptr == '0) ? c_last : r_rd_ptr - 1'b1;
               r_k      <= r_k + 1'b1;
`ifndef FIR_SEQ_MUL_PIPE_EN
               if (r_k == c_last) r_dout <= w_acc_next[OUT_SHIFT+OUTPUT_WIDTH-1:OUT_SHIFT];
`endif
            end
`ifdef FIR_SEQ_MUL_PIPE_EN
            c_st_drain: begin
               r_acc  <= w_acc_next;
               r_dout <= w_acc_next[OUT_SHIFT+OUTPUT_WIDTH-1:OUT_SHIFT];
            end
`endif
            c_st_done: begin
               r_wr_ptr <= (r_wr_ptr == c_last) ? '0 : r_wr_ptr + 1'b1;
            end
            default: ;
         endcase
      end
   end

endmodule
`default_nettype wire
